memory_bus_arbiter: RTL

Shares the single memory bus between NUM_MASTERS requesters: instruction fetch on port 0, CPU data on port 1 and loader/DMA on port 2. The memory subsystem accepts one transaction at a time: a single-cycle request pulse, then a single-cycle completion pulse. This block buffers one request per master, grants round-robin, issues exactly one bus transaction at a time and routes each completion back to its owner. It sits between the core/loader and the memory subsystem.

---
 rtl/memory_bus_arbiter_pkg.sv | 19 +
 rtl/memory_bus_arbiter_rr_picker.sv | 24 ++
 rtl/memory_bus_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: size codes, FSM states, error data.
package memory_bus_arbiter_pkg;

  localparam logic [2:0]  BHW_WORD = 3'b100;
  localparam logic [2:0]  BHW_HALF = 3'b010;
  localparam logic [2:0]  BHW_BYTE = 3'b001;
  localparam logic [31:0] ERR_DATA = 32'h0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // A size code the memory understands; anything else would hang the bus.
  function automatic logic bhw_legal(input logic [2:0] bhw);
    return (bhw == BHW_WORD) || (bhw == BHW_HALF) || (bhw == BHW_BYTE);
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_rr_picker.sv
// Round-robin scan: first set pending bit starting at i_start, wrapping around.
module rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_pending,
  input  logic [IDX_W-1:0] i_start,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  // Walk offsets from farthest to nearest so the nearest pending index wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_pending[(int'(i_start) + k) % N]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'((int'(i_start) + k) % N);
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// One-slot-per-master request buffer, round-robin grant, one bus transaction in flight.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_W       = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_MASTERS-1:0]    i_req_DV,
  input  logic [32*NUM_MASTERS-1:0] i_req_address,
  input  logic [32*NUM_MASTERS-1:0] i_req_data,
  input  logic [3*NUM_MASTERS-1:0]  i_req_bhw,
  input  logic [NUM_MASTERS-1:0]    i_req_write_notread,
  output logic [NUM_MASTERS-1:0]    o_rsp_DV,
  output logic [32*NUM_MASTERS-1:0] o_rsp_data,
  output logic                      o_bus_DV,
  output logic [31:0]               o_bus_address,
  output logic [31:0]               o_bus_data,
  output logic [2:0]                o_bus_bhw,
  output logic                      o_bus_write_notread,
  input  logic                      i_bus_DV,
  input  logic [31:0]               i_bus_data,
  output logic [IDX_W-1:0]          o_grant,
  output logic                      o_busy,
  output logic                      o_err
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               bus_dv_q, bus_dv_d;
  logic [31:0]        bus_addr_q, bus_addr_d;
  logic [31:0]        bus_data_q, bus_data_d;
  logic [2:0]         bus_bhw_q, bus_bhw_d;
  logic               bus_wr_q, bus_wr_d;

  logic [NUM_MASTERS-1:0] legal_pend;
  logic [NUM_MASTERS-1:0] err_set;
  logic [31:0]            slot_addr [NUM_MASTERS];
  logic [31:0]            slot_data [NUM_MASTERS];
  logic [2:0]             slot_bhw  [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] slot_wr;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   pick_start;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_slot
    logic        pend_q, pend_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  bhw_q, bhw_d;
    logic        wr_q, wr_d;
    logic        rsp_dv_q, rsp_dv_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        bus_done, bad_done, busy_after;

    assign bus_done   = (state_q == ST_WAIT) && i_bus_DV && (grant_q == IDX_W'(gi));
    assign bad_done   = pend_q && !bhw_legal(bhw_q);
    assign busy_after = pend_q && !bus_done && !bad_done;

    // Retire this cycle's completion first, then accept a new request into the freed slot.
    always_comb begin
      pend_d     = busy_after;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      bhw_d      = bhw_q;
      wr_d       = wr_q;
      rsp_dv_d   = bus_done || bad_done;
      rsp_data_d = rsp_data_q;
      if (bus_done) begin
        rsp_data_d = i_bus_data;
      end else if (bad_done) begin
        rsp_data_d = ERR_DATA;
      end
      if (i_req_DV[gi] && !busy_after) begin
        pend_d  = 1'b1;
        addr_d  = i_req_address[32*gi +: 32];
        wdata_d = i_req_data[32*gi +: 32];
        bhw_d   = i_req_bhw[3*gi +: 3];
        wr_d    = i_req_write_notread[gi];
      end
    end

    // Slot storage and this master's response register.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        pend_q     <= 1'b0;
        addr_q     <= '0;
        wdata_q    <= '0;
        bhw_q      <= '0;
        wr_q       <= 1'b0;
        rsp_dv_q   <= 1'b0;
        rsp_data_q <= '0;
      end else begin
        pend_q     <= pend_d;
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
        bhw_q      <= bhw_d;
        wr_q       <= wr_d;
        rsp_dv_q   <= rsp_dv_d;
        rsp_data_q <= rsp_data_d;
      end
    end

    assign legal_pend[gi]              = pend_q && bhw_legal(bhw_q);
    assign err_set[gi]                 = (i_req_DV[gi] && busy_after) || bad_done;
    assign slot_addr[gi]               = addr_q;
    assign slot_data[gi]               = wdata_q;
    assign slot_bhw[gi]                = bhw_q;
    assign slot_wr[gi]                 = wr_q;
    assign o_rsp_DV[gi]                = rsp_dv_q;
    assign o_rsp_data[32*gi +: 32]     = rsp_data_q;
  end

  assign pick_start = (grant_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;

  rr_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_pending (legal_pend),
    .i_start   (pick_start),
    .o_found   (pick_found),
    .o_idx     (pick_idx)
  );

  // Arbiter FSM: issue the picked slot from IDLE, then hold in WAIT until memory completes.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    err_d      = err_q | (|err_set);
    bus_dv_d   = 1'b0;
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    bus_bhw_d  = bus_bhw_q;
    bus_wr_d   = bus_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          for (int m = 0; m < NUM_MASTERS; m++) begin
            if (pick_idx == IDX_W'(m)) begin
              bus_addr_d = slot_addr[m];
              bus_data_d = slot_data[m];
              bus_bhw_d  = slot_bhw[m];
              bus_wr_d   = slot_wr[m];
            end
          end
          bus_dv_d = 1'b1;
          grant_d  = pick_idx;
          busy_d   = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_bus_DV) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered bus-side outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= IDX_W'(NUM_MASTERS - 1);
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      bus_dv_q   <= 1'b0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      bus_bhw_q  <= '0;
      bus_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      bus_dv_q   <= bus_dv_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      bus_bhw_q  <= bus_bhw_d;
      bus_wr_q   <= bus_wr_d;
    end
  end

  assign o_bus_DV            = bus_dv_q;
  assign o_bus_address       = bus_addr_q;
  assign o_bus_data          = bus_data_q;
  assign o_bus_bhw           = bus_bhw_q;
  assign o_bus_write_notread = bus_wr_q;
  assign o_grant             = grant_q;
  assign o_busy              = busy_q;
  assign o_err               = err_q;

endmodule
